// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite row fetcher.
// Holds default geometry, pixel format, colour key and the FSM state type.
package sprite_pkg;

    localparam int SPR_W  = 64;
    localparam int SPR_H  = 64;
    localparam int PIX_W  = 24;
    localparam int ADDR_W = 13;

    localparam logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/sprite_row_fetcher_if.sv
// Bundle between a sprite row fetcher, its ROM and its pixel consumer.
// Ports: fetch request/status, ROM address/data, buffer read index/pixel/opaque.
// master = client side (requester, ROM, colour mapper); slave = fetcher.
interface sprite_row_fetcher_if
    import sprite_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int PW = PIX_W,
    parameter int XW = $clog2(SPR_W),
    parameter int RW = $clog2(SPR_H)
);

    logic          fetch_req;
    logic [AW-1:0] fetch_base;
    logic [RW-1:0] fetch_row;
    logic          fetch_busy;
    logic          fetch_done;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] rom_data;
    logic [XW-1:0] rd_x;
    logic [PW-1:0] rd_pixel;
    logic          rd_opaque;

    modport master (
        output fetch_req, fetch_base, fetch_row, rom_data, rd_x,
        input  fetch_busy, fetch_done, rom_addr, rd_pixel, rd_opaque
    );

    modport slave (
        input  fetch_req, fetch_base, fetch_row, rom_data, rd_x,
        output fetch_busy, fetch_done, rom_addr, rd_pixel, rd_opaque
    );

endinterface

// File: rtl/sprite_line_buf.sv
// One-row sprite line buffer: simple dual-port RAM, sync write, sync
// read-before-write, plus a registered opaque flag aligned with rd_data.
// Ports: clk, rst, we/wr_idx/wr_data (write), rd_idx/rd_data/rd_opaque (read).
// Macro SPRITE_COLORKEY_EN: opaque = (pixel != KEY), else constant 1.
module sprite_line_buf #(
    parameter int                 DEPTH = 64,
    parameter int                 WIDTH = 24,
    parameter logic [WIDTH-1:0]   KEY   = 24'hFF00FF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_opaque
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset so partial rows survive a mid-fetch reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Reads see the pre-write contents on an index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

`ifdef SPRITE_COLORKEY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_opaque <= 1'b0;
        end else begin
            rd_opaque <= (mem[rd_idx] != KEY);
        end
    end
`else
    wire unused_key;
    assign unused_key = ^KEY;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_opaque <= 1'b0;
        end else begin
            rd_opaque <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from a 1-cycle-latency ROM into a line buffer,
// then serves pixels from it with one cycle of read latency.
// Ports: Clk, Reset (sync, active-high), bus (sprite_row_fetcher_if.slave).
// Macro SPRITE_COLORKEY_EN enables the transparent-colour comparator.
// The bus instance must be built with widths matching these parameters.
module sprite_row_fetcher #(
    parameter int                SPR_W     = 64,
    parameter int                SPR_H     = 64,
    parameter int                ADDR_W    = 13,
    parameter int                PIX_W     = 24,
    parameter logic [PIX_W-1:0]  KEY_COLOR = 24'hFF00FF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_row_fetcher_if.slave  bus
);
    import sprite_pkg::*;

    localparam int XW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    localparam logic [XW-1:0]     LAST_COL = XW'(SPR_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [XW-1:0]     col;
    logic [XW-1:0]     col_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_nx;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     row_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_off;
    logic              done_q;
    logic              done_nx;
    logic              wr_en;
    logic [XW-1:0]     wr_idx;

    // Address arithmetic wraps modulo 2^ADDR_W.
    assign row_off = ADDR_W'(row_q) * ROW_STEP;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            col    <= '0;
            base_q <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
            wr_en  <= 1'b0;
            wr_idx <= '0;
        end else begin
            state  <= state_nx;
            col    <= col_nx;
            base_q <= base_nx;
            row_q  <= row_nx;
            done_q <= done_nx;
            // ROM data lands one cycle after its address: delay col to match.
            wr_en  <= (state == FETCH);
            wr_idx <= col;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        base_nx  = base_q;
        row_nx   = row_q;
        addr     = '0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.fetch_req) begin
                    base_nx  = bus.fetch_base;
                    row_nx   = bus.fetch_row;
                    col_nx   = '0;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                addr   = base_q + row_off + ADDR_W'(col);
                col_nx = col + 1'b1;
                if (col == LAST_COL) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.rom_addr   = addr;
    assign bus.fetch_busy = (state != IDLE);
    assign bus.fetch_done = done_q;

    sprite_line_buf #(
        .DEPTH (SPR_W),
        .WIDTH (PIX_W),
        .KEY   (KEY_COLOR)
    ) u_buf (
        .clk       (Clk),
        .rst       (Reset),
        .we        (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (bus.rom_data),
        .rd_idx    (bus.rd_x),
        .rd_data   (bus.rd_pixel),
        .rd_opaque (bus.rd_opaque)
    );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a mem[a]=a ROM model.
// Covers reset, row fetch, address wrap, back-to-back, reset abort, colour key.
module tb_sprite_row_fetcher;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sprite_row_fetcher_if bus ();

    sprite_row_fetcher dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [13:0] key_addr = 14'h3FFF;

    function automatic logic [23:0] rom_word(input logic [12:0] a);
        if ({1'b0, a} == key_addr) return 24'hFF00FF;
        return {11'b0, a};
    endfunction

    // ROM model: registered read, one cycle of latency.
    always @(posedge Clk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.fetch_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic start(input logic [12:0] base, input logic [5:0] row);
        bus.fetch_base = base;
        bus.fetch_row  = row;
        bus.fetch_req  = 1'b1;
        tick();
        bus.fetch_req  = 1'b0;
    endtask

    int cyc;
    int n_done;
    logic [12:0] exp_a;

    initial begin
        Reset          = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_base = '0;
        bus.fetch_row  = '0;
        bus.rd_x       = '0;
        tick();
        tick();
        chk("rst_busy",   32'(bus.fetch_busy), 32'd0);
        chk("rst_done",   32'(bus.fetch_done), 32'd0);
        chk("rst_addr",   32'(bus.rom_addr),   32'd0);
        chk("rst_pixel",  32'(bus.rd_pixel),   32'd0);
        chk("rst_opaque", 32'(bus.rd_opaque),  32'd0);
        Reset = 1'b0;
        tick();

        // Row 3 of base 0: addresses 192..255.
        start(13'h0000, 6'd3);
        for (int k = 0; k < 64; k++) begin
            chk("row3_addr", 32'(bus.rom_addr), 32'(192 + k));
            tick();
        end
        chk("drain_busy", 32'(bus.fetch_busy), 32'd1);
        chk("drain_done", 32'(bus.fetch_done), 32'd0);
        chk("drain_addr", 32'(bus.rom_addr),   32'd0);
        tick();
        chk("done_pulse", 32'(bus.fetch_done), 32'd1);
        chk("done_busy",  32'(bus.fetch_busy), 32'd0);
        tick();
        chk("done_low",   32'(bus.fetch_done), 32'd0);
        for (int x = 0; x < 64; x++) begin
            bus.rd_x = 6'(x);
            tick();
            chk("row3_pix", 32'(bus.rd_pixel), 32'(192 + x));
        end

        // Address wrap from 1FF0.
        start(13'h1FF0, 6'd0);
        for (int k = 0; k < 64; k++) begin
            exp_a = (k < 16) ? 13'(13'h1FF0 + k) : 13'(k - 16);
            chk("wrap_addr", 32'(bus.rom_addr), 32'(exp_a));
            tick();
        end
        wait_done(cyc);
        chk("wrap_done", 32'(cyc), 32'd1);
        bus.rd_x = 6'd16;
        tick();
        chk("wrap_pix16", 32'(bus.rd_pixel), 32'h0000);
        bus.rd_x = 6'd15;
        tick();
        chk("wrap_pix15", 32'(bus.rd_pixel), 32'h1FFF);

        // Read index 10 while it is being overwritten (written at E12).
        bus.rd_x = 6'd10;
        start(13'h0000, 6'd3);
        repeat (11) tick();
        chk("rdf_e11", 32'(bus.rd_pixel), 32'h1FFA);
        tick();
        chk("rdf_e12", 32'(bus.rd_pixel), 32'h1FFA);
        tick();
        chk("rdf_e13", 32'(bus.rd_pixel), 32'd202);
        wait_done(cyc);
        chk("rdf_done", 32'(cyc), 32'd52);

        // Back-to-back with request held high.
        tick();
        bus.fetch_base = 13'h0000;
        bus.fetch_row  = 6'd1;
        bus.fetch_req  = 1'b1;
        tick();
        wait_done(cyc);
        chk("b2b_first", 32'(cyc), 32'd65);
        tick();
        chk("b2b_busy", 32'(bus.fetch_busy), 32'd1);
        chk("b2b_addr0", 32'(bus.rom_addr), 32'd64);
        repeat (10) tick();
        chk("b2b_addr10", 32'(bus.rom_addr), 32'd74);
        bus.fetch_req = 1'b0;
        wait_done(cyc);
        chk("b2b_second", 32'(cyc), 32'd55);
        tick();
        chk("b2b_idle", 32'(bus.fetch_busy), 32'd0);
        bus.rd_x = 6'd7;
        tick();
        chk("b2b_pix7", 32'(bus.rd_pixel), 32'd71);

        // Reset 20 cycles into a fetch.
        start(13'h0000, 6'd2);
        repeat (20) tick();
        Reset = 1'b1;
        tick();
        chk("abort_busy",  32'(bus.fetch_busy), 32'd0);
        chk("abort_done",  32'(bus.fetch_done), 32'd0);
        chk("abort_addr",  32'(bus.rom_addr),   32'd0);
        chk("abort_pixel", 32'(bus.rd_pixel),   32'd0);
        Reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.fetch_done) n_done++;
        end
        chk("abort_nodone", 32'(n_done), 32'd0);

        // Colour key on pixel 5 of row 0.
        key_addr = 14'd5;
        start(13'h0000, 6'd0);
        wait_done(cyc);
        chk("key_done", 32'(cyc), 32'd65);
        bus.rd_x = 6'd5;
        tick();
        chk("key_pix5", 32'(bus.rd_pixel), 32'hFF00FF);
`ifdef SPRITE_COLORKEY_EN
        chk("key_opq5", 32'(bus.rd_opaque), 32'd0);
`else
        chk("key_opq5", 32'(bus.rd_opaque), 32'd1);
`endif
        bus.rd_x = 6'd6;
        tick();
        chk("key_pix6", 32'(bus.rd_pixel), 32'd6);
        chk("key_opq6", 32'(bus.rd_opaque), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
